feature_pair_merger: RTL and testbench

FEATURE_PAIR_MERGER -- requirements
Module: feature_pair_merger

---
 rtl/feature_pair_merger.sv | 114 +++++++++++
 tb/tb_feature_pair_merger.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/feature_pair_merger.sv
// Pairs pooled samples from two independent channels through per-channel FIFOs
// and emits {ch1, ch0} with a raster index over a (W-2)x(H-2) frame.
module feature_pair_merger #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in0,
  input  logic signed [DATA_WIDTH-1:0]  data_in0,
  input  logic                          valid_in1,
  input  logic signed [DATA_WIDTH-1:0]  data_in1,
  input  logic [7:0]                    img_width,
  input  logic [7:0]                    img_height,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DATA_WIDTH-1:0]       out_data,
  output logic [15:0]                   out_index,
  output logic                          frame_done,
  output logic                          ovf0,
  output logic                          ovf1
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem0 [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [FIFO_DEPTH];
  logic [AW:0]           wr0, rd0, wr1, rd1;

  logic empty0, empty1, full0, full1;
  logic pop, push0, push1, transfer;
  logic [15:0] e_now, e_reg, active_e;
  logic        deg_now, deg_reg, active_deg;
  logic        last_pair;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty0 = (wr0 == rd0);
  assign empty1 = (wr1 == rd1);
  assign full0  = (wr0[AW] != rd0[AW]) && (wr0[AW-1:0] == rd0[AW-1:0]);
  assign full1  = (wr1[AW] != rd1[AW]) && (wr1[AW-1:0] == rd1[AW-1:0]);

  assign transfer = out_valid && out_ready;
  assign pop      = !clear && !empty0 && !empty1 && (!out_valid || out_ready);
  assign push0    = !clear && valid_in0 && (!full0 || pop);
  assign push1    = !clear && valid_in1 && (!full1 || pop);

  assign e_now   = (16'(img_width) - 16'd2) * (16'(img_height) - 16'd2);
  assign deg_now = (img_width < 8'd3) || (img_height < 8'd3);

  // Frame geometry follows the inputs while idle and freezes once a frame is underway.
  assign active_e   = (out_index == 16'd0) ? e_now   : e_reg;
  assign active_deg = (out_index == 16'd0) ? deg_now : deg_reg;
  assign last_pair  = !active_deg && (out_index == active_e - 16'd1);

  always_ff @(posedge clk) begin
    if (push0) mem0[wr0[AW-1:0]] <= data_in0;
    if (push1) mem1[wr1[AW-1:0]] <= data_in1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr0        <= '0;
      rd0        <= '0;
      wr1        <= '0;
      rd1        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      frame_done <= 1'b0;
      ovf0       <= 1'b0;
      ovf1       <= 1'b0;
      e_reg      <= '0;
      deg_reg    <= 1'b1;
    end else if (clear) begin
      wr0        <= '0;
      rd0        <= '0;
      wr1        <= '0;
      rd1        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      frame_done <= 1'b0;
      ovf0       <= 1'b0;
      ovf1       <= 1'b0;
    end else begin
      if (push0) wr0 <= wr0 + 1'b1;
      if (push1) wr1 <= wr1 + 1'b1;
      if (valid_in0 && full0 && !pop) ovf0 <= 1'b1;
      if (valid_in1 && full1 && !pop) ovf1 <= 1'b1;

      if (pop) begin
        rd0       <= rd0 + 1'b1;
        rd1       <= rd1 + 1'b1;
        out_data  <= {mem1[rd1[AW-1:0]], mem0[rd0[AW-1:0]]};
        out_valid <= 1'b1;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end

      if (out_index == 16'd0) begin
        e_reg   <= e_now;
        deg_reg <= deg_now;
      end

      frame_done <= transfer && last_pair;
      if (transfer) begin
        if (active_deg || last_pair) out_index <= '0;
        else                         out_index <= out_index + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_feature_pair_merger.sv
// Scoreboard bench for feature_pair_merger: directed stimulus pushes expected
// pairs into a queue; a negedge monitor pops and compares on every transfer.
module tb_feature_pair_merger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in0 = 1'b0, valid_in1 = 1'b0;
  logic signed [15:0] data_in0 = '0, data_in1 = '0;
  logic [7:0]  img_width = 8'd5, img_height = 8'd5;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [15:0] out_index;
  logic        frame_done, ovf0, ovf1;

  feature_pair_merger #(.DATA_WIDTH(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in0(valid_in0), .data_in0(data_in0),
    .valid_in1(valid_in1), .data_in1(data_in1),
    .img_width(img_width), .img_height(img_height),
    .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .frame_done(frame_done), .ovf0(ovf0), .ovf1(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fd_count = 0;
  logic fd_expect = 1'b0;
  logic held = 1'b0;
  logic [31:0] held_data;
  logic [15:0] held_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare transfers, frame_done timing and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      fd_expect = 1'b0;
      held = 1'b0;
    end else begin
      check("frame_done", {31'd0, frame_done}, {31'd0, fd_expect});
      if (frame_done) fd_count++;
      fd_expect = 1'b0;
      if (held && out_valid) begin
        check("stall_data", out_data, held_data);
        check("stall_index", {16'd0, out_index}, {16'd0, held_idx});
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      held_idx = out_index;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pair: got data %0h index %0d, none expected", out_data, out_index);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pair_data", out_data, e.data);
          check("pair_index", {16'd0, out_index}, {16'd0, e.idx});
          fd_expect = e.last;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v0, input logic [15:0] d0, input logic v1, input logic [15:0] d1);
    valid_in0 = v0; data_in0 = d0;
    valid_in1 = v1; data_in1 = d1;
    tick();
    valid_in0 = 1'b0; valid_in1 = 1'b0;
  endtask

  task automatic expect_pair(input logic [15:0] d1, input logic [15:0] d0, input logic [15:0] idx, input logic last);
    exp_t e;
    e.data = {d1, d0};
    e.idx = idx;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d pairs outstanding, 0 required", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  // Lockstep frame: pair i is {-(i+1), 100+i}.
  task automatic lockstep_frame(input int n, input int e, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      expect_pair(16'(-(i + 1)), 16'(100 + i), (e > 0) ? 16'(i % e) : 16'd0,
                  (e > 0) && ((i % e) == e - 1));
      feed(1'b1, 16'(100 + i), 1'b1, 16'(-(i + 1)));
    end
  endtask

  int fd_base;

  initial begin
    repeat (2) tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_index", {16'd0, out_index}, 32'd0);
    check("rst_ovf", {30'd0, ovf1, ovf0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full 5x5 frame, lockstep, always ready.
    img_width = 8'd5; img_height = 8'd5;
    fd_base = fd_count;
    lockstep_frame(9, 9, 1'b0);
    drain(1'b0);
    check("frame5_done_count", 32'(fd_count - fd_base), 32'd1);
    check("frame5_ovf", {30'd0, ovf1, ovf0}, 32'd0);

    // Channel 0 arrives first; nothing may appear until channel 1 catches up.
    feed(1'b1, 16'd10, 1'b0, 16'd0);
    feed(1'b1, 16'd20, 1'b0, 16'd0);
    feed(1'b1, 16'd30, 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check("ch0_only_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    expect_pair(16'hFFFF, 16'd10, 16'd0, 1'b0);
    expect_pair(16'hFFFE, 16'd20, 16'd1, 1'b0);
    expect_pair(16'hFFFD, 16'd30, 16'd2, 1'b0);
    feed(1'b0, 16'd0, 1'b1, 16'hFFFF);
    feed(1'b0, 16'd0, 1'b1, 16'hFFFE);
    feed(1'b0, 16'd0, 1'b1, 16'hFFFD);
    drain(1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_index", {16'd0, out_index}, 32'd0);

    // Overflow: 17 samples into a 16-deep channel-0 FIFO with output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) feed(1'b1, 16'(500 + i), 1'b0, 16'd0);
    check("ovf0_at_16", {31'd0, ovf0}, 32'd0);
    feed(1'b1, 16'd999, 1'b0, 16'd0);
    check("ovf0_at_17", {31'd0, ovf0}, 32'd1);
    check("ovf1_at_17", {31'd0, ovf1}, 32'd0);
    check("ovf_no_valid", {31'd0, out_valid}, 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("ovf0_cleared", {31'd0, ovf0}, 32'd0);
    out_ready = 1'b1;

    // Degenerate geometry: pairs pass, index pinned at 0, no frame_done.
    img_width = 8'd2; img_height = 8'd5;
    fd_base = fd_count;
    lockstep_frame(3, 0, 1'b0);
    drain(1'b0);
    check("degen_done_count", 32'(fd_count - fd_base), 32'd0);

    // 6x6 frame (16 pairs) with random backpressure.
    img_width = 8'd6; img_height = 8'd6;
    fd_base = fd_count;
    lockstep_frame(16, 16, 1'b1);
    drain(1'b1);
    check("frame6_done_count", 32'(fd_count - fd_base), 32'd1);
    check("frame6_ovf", {30'd0, ovf1, ovf0}, 32'd0);

    // Reset mid-frame after 4 pairs; stale channel-0 samples must be lost.
    img_width = 8'd5; img_height = 8'd5;
    lockstep_frame(4, 9, 1'b0);
    drain(1'b0);
    feed(1'b1, 16'd77, 1'b0, 16'd0);
    feed(1'b1, 16'd78, 1'b0, 16'd0);
    out_ready = 1'b0;
    expect_pair(16'hFFFF, 16'd1, 16'd0, 1'b0);
    feed(1'b1, 16'd1, 1'b1, 16'hFFFF);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_out_index", {16'd0, out_index}, 32'd0);
    check("mid_rst_flags", {29'd0, frame_done, ovf1, ovf0}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    fd_base = fd_count;
    lockstep_frame(9, 9, 1'b0);
    drain(1'b0);
    check("post_rst_done_count", 32'(fd_count - fd_base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
